// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel synchronizer, edge qualifier and one-deep
// pending slot, with a round-robin scheduler driving a single registered valid/ready port.
module edge_event_arbiter #(
  parameter int unsigned NrChannels = 4,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned IdxWidth   = $clog2(NrChannels)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [NrChannels-1:0] serial_i,
  input  logic [NrChannels-1:0] en_i,
  input  logic [NrChannels-1:0] rise_en_i,
  input  logic [NrChannels-1:0] fall_en_i,
  output logic [NrChannels-1:0] level_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [IdxWidth-1:0]   evt_idx_o,
  output logic                  evt_rise_o,
  output logic [NrChannels-1:0] overflow_o
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e                state_q;
  logic [NrChannels-1:0] sync_q [STAGES];
  logic [NrChannels-1:0] prev_q;
  logic [NrChannels-1:0] pend_q, pend_d;
  logic [NrChannels-1:0] ptype_q, ptype_d;
  logic [NrChannels-1:0] ovf_q, ovf_d;
  logic [IdxWidth-1:0]   ptr_q;
  logic                  valid_q;
  logic [IdxWidth-1:0]   idx_q;
  logic                  rise_q;

  logic [NrChannels-1:0] rise_w, fall_w, edge_w;
  logic                  gnt_found;
  logic [IdxWidth-1:0]   gnt_idx;
  logic [IdxWidth-1:0]   ptr_next;
  logic                  gnt_fire;
  logic [NrChannels-1:0] gnt_vec;

  assign level_o     = sync_q[STAGES-1];
  assign evt_valid_o = valid_q;
  assign evt_idx_o   = idx_q;
  assign evt_rise_o  = rise_q;
  assign overflow_o  = ovf_q;

  // prev_q follows the level regardless of en_i so re-enabling never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= serial_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= level_o;
    end
  end

  assign rise_w = en_i & rise_en_i & level_o & ~prev_q;
  assign fall_w = en_i & fall_en_i & ~level_o & prev_q;
  assign edge_w = rise_w | fall_w;

  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NrChannels; i++) begin
      cand = (32'(ptr_q) + i) % NrChannels;
      if (!gnt_found && pend_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxWidth'(cand);
      end
    end
  end

  assign ptr_next = (gnt_idx == IdxWidth'(NrChannels - 1)) ? '0 : gnt_idx + IdxWidth'(1);
  assign gnt_fire = gnt_found && !clr_i && (state_q == StIdle || evt_ready_i);

  always_comb begin
    gnt_vec = '0;
    if (gnt_fire) gnt_vec[gnt_idx] = 1'b1;
  end

  // A slot being granted this cycle counts as free for a newly arriving edge.
  always_comb begin
    pend_d  = pend_q;
    ptype_d = ptype_q;
    ovf_d   = ovf_q;
    for (int c = 0; c < NrChannels; c++) begin
      if (gnt_vec[c]) pend_d[c] = 1'b0;
      if (edge_w[c]) begin
        if (pend_q[c] && !gnt_vec[c]) begin
          ovf_d[c] = 1'b1;
        end else begin
          pend_d[c]  = 1'b1;
          ptype_d[c] = rise_w[c];
        end
      end
    end
    if (clr_i) begin
      pend_d = '0;
      ovf_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      ptype_q <= '0;
      ovf_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      idx_q   <= '0;
      rise_q  <= 1'b0;
      ptr_q   <= '0;
    end else if (clr_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_fire) begin
            idx_q   <= gnt_idx;
            rise_q  <= ptype_q[gnt_idx];
            valid_q <= 1'b1;
            ptr_q   <= ptr_next;
            state_q <= StOffer;
          end
        end
        StOffer: begin
          if (evt_ready_i) begin
            if (gnt_fire) begin
              idx_q  <= gnt_idx;
              rise_q <= ptype_q[gnt_idx];
              ptr_q  <= ptr_next;
            end else begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: a vector table for latency and round-robin order,
// followed by hand-written sequences for backpressure, overflow, enable and soft clear.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst, clr, ready, valid, rise;
  logic [3:0] serial, en, rise_en, fall_en, level, ovf;
  logic [1:0] idx;

  int total = 0;
  int bad   = 0;

  edge_event_arbiter #(.NrChannels(4), .STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .serial_i    (serial),
    .en_i        (en),
    .rise_en_i   (rise_en),
    .fall_en_i   (fall_en),
    .level_o     (level),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_idx_o   (idx),
    .evt_rise_o  (rise),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] serial;
    logic [3:0] fall_en;
    logic       clr;
    logic       ready;
    logic       valid;
    logic [1:0] idx;
    logic       rise;
    logic [3:0] level;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl [24];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_evt(input string name, input logic [1:0] eidx, input logic erise);
    chk({name, ".valid"}, 32'(valid), 32'd1);
    chk({name, ".idx"}, 32'(idx), 32'(eidx));
    chk({name, ".rise"}, 32'(rise), 32'(erise));
  endtask

  initial begin
    //          serial   fall_en  clr   rdy   valid idx    rise  level    ovf
    tbl[0]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0010, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0010, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[3]  = '{4'b0010, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[4]  = '{4'b0010, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000};
    tbl[5]  = '{4'b0010, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[6]  = '{4'b0010, 4'hF, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[7]  = '{4'b1111, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[8]  = '{4'b1111, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000};
    tbl[9]  = '{4'b1111, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000};
    tbl[10] = '{4'b1111, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b1111, 4'b0000};
    tbl[11] = '{4'b1111, 4'hF, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'b1111, 4'b0000};
    tbl[12] = '{4'b1111, 4'hF, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1111, 4'b0000};
    tbl[13] = '{4'b1111, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000};
    tbl[14] = '{4'b0010, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000};
    tbl[15] = '{4'b0010, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[16] = '{4'b0010, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[17] = '{4'b0010, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[18] = '{4'b1011, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[19] = '{4'b1011, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1011, 4'b0000};
    tbl[20] = '{4'b1011, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1011, 4'b0000};
    tbl[21] = '{4'b1011, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b1011, 4'b0000};
    tbl[22] = '{4'b1011, 4'hF, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1011, 4'b0000};
    tbl[23] = '{4'b1011, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1011, 4'b0000};

    rst = 1'b1; clr = 1'b0; ready = 1'b1;
    en = 4'hF; rise_en = 4'hF; fall_en = 4'hF; serial = 4'hF;
    tick(1);
    chk("rst1.valid", 32'(valid), 32'd0);
    chk("rst1.level", 32'(level), 32'd0);
    chk("rst1.ovf", 32'(ovf), 32'd0);
    chk("rst1.idx", 32'(idx), 32'd0);
    chk("rst1.rise", 32'(rise), 32'd0);
    serial = 4'h0;
    tick(1);
    chk("rst2.valid", 32'(valid), 32'd0);
    chk("rst2.level", 32'(level), 32'd0);
    rst = 1'b0;

    for (int r = 0; r < 24; r++) begin
      serial  = tbl[r].serial;
      fall_en = tbl[r].fall_en;
      clr     = tbl[r].clr;
      ready   = tbl[r].ready;
      tick(1);
      chk($sformatf("row%0d.valid", r), 32'(valid), 32'(tbl[r].valid));
      chk($sformatf("row%0d.level", r), 32'(level), 32'(tbl[r].level));
      chk($sformatf("row%0d.ovf", r), 32'(ovf), 32'(tbl[r].ovf));
      if (tbl[r].valid) begin
        chk($sformatf("row%0d.idx", r), 32'(idx), 32'(tbl[r].idx));
        chk($sformatf("row%0d.rise", r), 32'(rise), 32'(tbl[r].rise));
      end
    end
    clr = 1'b0;
    fall_en = 4'hF;

    // Backpressure: offered event held, second edge refills slot, third overflows.
    ready = 1'b0;
    serial = 4'b1111;
    tick(3);
    chk("bp.idle", 32'(valid), 32'd0);
    tick(1);
    chk_evt("bp.offer", 2'd2, 1'b1);
    serial = 4'b1011;
    tick(3);
    chk_evt("bp.hold", 2'd2, 1'b1);
    chk("bp.ovf0", 32'(ovf), 32'd0);
    serial = 4'b1111;
    tick(2);
    chk("bp.ovf1", 32'(ovf), 32'd0);
    tick(1);
    chk("bp.ovf2", 32'(ovf), 32'b0100);
    chk_evt("bp.hold2", 2'd2, 1'b1);
    ready = 1'b1;
    tick(1);
    chk_evt("bp.fall", 2'd2, 1'b0);
    chk("bp.ovf3", 32'(ovf), 32'b0100);
    tick(1);
    chk("bp.drain", 32'(valid), 32'd0);
    chk("bp.ovf4", 32'(ovf), 32'b0100);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("bp.clr", 32'(ovf), 32'd0);

    // Same-cycle grant and new edge on ch0.
    fall_en = 4'b1110;
    serial = 4'b1110;
    tick(4);
    chk("sg.quiet", 32'(valid), 32'd0);
    fall_en = 4'hF;
    serial = 4'b1111;
    tick(1);
    serial = 4'b1110;
    tick(2);
    chk("sg.idle", 32'(valid), 32'd0);
    tick(1);
    chk_evt("sg.rise", 2'd0, 1'b1);
    chk("sg.ovf", 32'(ovf), 32'd0);
    tick(1);
    chk_evt("sg.fall", 2'd0, 1'b0);
    tick(1);
    chk("sg.done", 32'(valid), 32'd0);
    chk("sg.ovf2", 32'(ovf), 32'd0);

    // Toggling a disabled channel produces nothing, level still tracks.
    en = 4'b0111;
    serial = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("en.off", 32'(valid), 32'd0);
    end
    chk("en.lvl0", 32'(level), 32'b0110);
    serial = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("en.off2", 32'(valid), 32'd0);
    end
    chk("en.lvl1", 32'(level), 32'b1110);
    en = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("en.reen", 32'(valid), 32'd0);
    end

    // Clear while an event is offered and two more are pending.
    ready = 1'b0;
    serial = 4'b0011;
    tick(3);
    chk("cl.idle", 32'(valid), 32'd0);
    tick(1);
    chk("cl.offer", 32'(valid), 32'd1);
    tick(1);
    chk("cl.held", 32'(valid), 32'd1);
    clr = 1'b1;
    ready = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("cl.valid", 32'(valid), 32'd0);
    chk("cl.ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("cl.quiet", 32'(valid), 32'd0);
    end
    chk("cl.lvl", 32'(level), 32'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller for asynchronous single-bit inputs such as GPIO, interrupt lines and handshake strobes.
- Each channel synchronizes its input and detects qualified rising/falling edges.
- Each channel holds one pending event.
- A round-robin scheduler shares a single registered valid/ready event port among all channels; overruns are flagged per channel.

Parameters:
NrChannels, 4, number of input channels (>=2)
STAGES, 2, synchronizer depth per channel (>=2)
IdxWidth, $clog2(NrChannels), derived; width of channel index

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
clr_i  input  1  synchronous soft clear (see Behaviour)
serial_i  input  NrChannels  asynchronous channel inputs
en_i  input  NrChannels  per-channel edge-detection enable
rise_en_i  input  NrChannels  report rising edges
fall_en_i  input  NrChannels  report falling edges
level_o  output  NrChannels  synchronized level per channel
evt_valid_o  output  1  event offered
evt_ready_i  input  1  consumer accepts event
evt_idx_o  output  IdxWidth  channel of offered event
evt_rise_o  output  1  1=rising edge, 0=falling edge
overflow_o  output  NrChannels  sticky: edge lost because the channel's pending slot was full

Behaviour:
- Reset (rst_i=1, sampled at clk edge):
  - All synchronizer stages, prev flops, pending, pending type and overflow_o go to 0.
  - evt_valid_o, evt_idx_o and evt_rise_o go to 0.
  - RR pointer goes to 0; FSM goes to IDLE.
  - rst_i has priority over clr_i.
- Synchronizer:
  - STAGES-flop chain per channel; level_o = last stage.
  - prev[c] <= level_o[c] every cycle, independent of en_i.
  - Re-enabling a channel therefore never produces a spurious edge.
- Edge qualification:
  - rise[c] = en_i[c] & rise_en_i[c] & level_o[c] & ~prev[c]
  - fall[c] = en_i[c] & fall_en_i[c] & ~level_o[c] & prev[c]
  - rise and fall are mutually exclusive.
- Pending slot per channel (pend, ptype):
  - A qualified edge with the slot empty, or with the slot being granted this cycle, sets pend=1 and ptype=rise.
  - A qualified edge with the slot full and not granted this cycle keeps the old event, drops the new one, and sets overflow_o[c].
  - overflow_o is cleared only by rst_i or clr_i.
- Scheduler FSM:
  - IDLE: if any pend, grant the first pending channel searching from RR pointer upward with wrap. Load evt_idx_o/evt_rise_o, clear that pend, set evt_valid_o, pointer <= grant+1 mod NrChannels, go to OFFER.
  - OFFER: evt_valid_o=1; evt_idx_o and evt_rise_o are stable until the handshake.
  - On evt_valid_o & evt_ready_i: if any pend (excluding edges arriving this same cycle), grant the next channel in the same cycle (back-to-back, one event per cycle). Otherwise clear evt_valid_o and go to IDLE.
  - Disabling a channel does not cancel its pending or offered event.
- Latency:
  - Input stable before edge t: level_o changes after edge t+STAGES-1, pend sets after edge t+STAGES, evt_valid_o rises after edge t+STAGES+1.
  - STAGES=2 gives 3 cycles.
- Soft clear (clr_i=1):
  - Clears pend, overflow_o, evt_valid_o and the RR pointer; FSM goes to IDLE.
  - Edges detected in the clear cycle are discarded.
  - Synchronizer chains and prev flops run normally.
  - A transfer in progress is aborted even if evt_ready_i=1 in the same cycle.
- Throughput: at most one event per cycle. With evt_ready_i tied high, all channels are serviced fairly, each within NrChannels grants.

Test Plan:
- Reset/latency: rst_i 1 for 2 cycles, then ch1 serial_i 0->1 with rise_en=1, en=1, ready=1 -> evt_valid_o exactly 3 cycles later, idx=1, rise=1, one cycle wide. All outputs 0 during reset.
- Round-robin: ch0, ch2 and ch3 rise in the same cycle, ready=1 -> events idx 0,2,3 on consecutive cycles. Next simultaneous ch0+ch3 burst -> order 0,3 (pointer at 0 after wrap). No overflow.
- Backpressure/overflow: ready=0, ch2 toggles 0->1->0 -> offered event idx=2 rise=1 held stable; second (fall) edge refills the pending slot. A third edge sets overflow_o[2]=1. Then ready=1 -> fall event delivered, overflow_o[2] stays 1 until clr_i.
- Same-cycle grant and edge: ch0 pending granted in the cycle its new fall edge arrives -> fall becomes pending, overflow_o[0]=0, delivered next.
- Qualification/enable: fall_en=0 -> falling edges produce no event. Toggle input while en_i=0, then re-enable -> no event. Level_o still tracks the input.
- Clear mid-offer: evt_valid_o=1 with ready=0 and two channels pending; assert clr_i for 1 cycle with ready=1 -> evt_valid_o=0 next cycle, no further events, overflow_o all 0.
